// File: rtl/obi_mem_responder_if.sv
// OBI request/response signal bundle between a bus master (core side) and
// the memory responder. The master modport drives requests and the throttle;
// the slave modport drives grant and the response channel.
interface obi_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        stall_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/obi_mem_responder.sv
// OBI subordinate backed by a word-addressed SRAM. Every accepted request is
// answered after a fixed latency through an in-order shift pipeline; requests
// outside the memory window are answered with an error. A small counter bounds
// how many accepted requests may be waiting for their response.
module obi_mem_responder #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WORDS           = 1024,
    parameter int          RESP_LATENCY    = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic                 clk,
    input logic                 rst,
    obi_mem_responder_if.slave  bus
);
    localparam int          AW           = $clog2(WORDS);
    localparam int          CW           = $clog2(MAX_OUTSTANDING + 1);
    // Window size kept 33 bits wide so a 4 GiB window cannot wrap to zero.
    localparam logic [32:0] WINDOW_BYTES = 33'(WORDS) << 2;

    logic [31:0]   mem [WORDS];

    logic [CW-1:0] outstanding;
    logic [31:0]   offset;
    logic          hit;
    logic [AW-1:0] word_idx;
    logic          accept;

    logic          pipe_valid [RESP_LATENCY];
    logic          pipe_err   [RESP_LATENCY];
    logic [31:0]   pipe_data  [RESP_LATENCY];

    assign offset   = bus.addr_i - BASE_ADDR;
    assign hit      = {1'b0, offset} < WINDOW_BYTES;
    assign word_idx = offset[AW+1:2];

    // Grant is purely a function of request, throttle and free response slots;
    // it deliberately ignores address, direction and byte enables.
    assign bus.gnt_o = bus.req_i && !bus.stall_i && (outstanding < CW'(MAX_OUTSTANDING));
    assign accept    = bus.req_i && bus.gnt_o;

    assign bus.rvalid_o = pipe_valid[RESP_LATENCY-1];
    assign bus.err_o    = pipe_err[RESP_LATENCY-1];
    assign bus.rdata_o  = pipe_data[RESP_LATENCY-1];

    // Byte-lane writes into the array; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && hit && bus.we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be_i[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the response on accept (reads see the
    // pre-write word), later stages shift it toward the outputs. Idle stages
    // carry zeros so rdata/err are 0 whenever rvalid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < RESP_LATENCY; k++) begin
                pipe_valid[k] <= 1'b0;
                pipe_err[k]   <= 1'b0;
                pipe_data[k]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !hit;
            pipe_data[0]  <= (accept && hit && !bus.we_i) ? mem[word_idx] : '0;
            for (int k = 1; k < RESP_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_err[k]   <= pipe_err[k-1];
                pipe_data[k]  <= pipe_data[k-1];
            end
        end
    end

    // Track accepted-but-unanswered requests; accept and retire in the same
    // cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({accept, bus.rvalid_o})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule
